// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small power-of-two FIFO with valid/ready read side.
// Frame errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 10416,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic [2:0]                  state_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  // Read side handshake: a byte moves when valid_o and ready_i are both high
  // on a rising edge; ready_i is ignored while valid_o is low.

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            rx_meta_q, rxs_q;
  logic            frame_err_q, overrun_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic push_req, full, pop, wr_en;

  assign push_req = (state_q == STOP) && (cnt_q == FULL_CNT) && rxs_q;
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = (count_q != '0) && ready_i;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en    = push_req && (!full || pop);

  always_ff @(posedge clk_i or posedge nreset_i) begin
    if (nreset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rxs_q       <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= push_req && full && !pop;
      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q     <= '0;
            shreg_q   <= {rxs_q, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge nreset_i) begin
    if (nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (16 clocks/bit, 4-entry FIFO) with a
// scoreboard queue checked by an independent read-side monitor.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clk_i = 1'b0;
  logic       nreset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] count_o;
  logic       frame_err_o, overrun_o;
  logic [2:0] state_o;

  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  uart_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .rx_i(rx_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    ready_i = 1'b1;
    while ((valid_o || exp_q.size() != 0) && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    ready_i = 1'b0;
    chk({name, "_drain_done"}, (t < 200), 1);
    chk({name, "_count_after_drain"}, count_o, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (valid_o && ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_fail++;
          $display("FAIL rx_byte: got %0h expected %0h", data_o, e);
        end
      end
    end
    if (frame_err_o) ferr_cnt++;
    if (overrun_o)   ovr_cnt++;
    if (frame_err_o || overrun_o) chk("err_exclusive", frame_err_o & overrun_o, 0);
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_state", state_o, ST_IDLE);
    nreset_i = 1'b0;
    idle(4);

    // single frame with latency check: 2 + 152 + 1 cycles after the start edge
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk_i);
        #1;
        chk("a5_not_early", valid_o, 0);
        @(posedge clk_i);
        #1;
        chk("a5_valid", valid_o, 1);
        chk("a5_data", data_o, 8'hA5);
        chk("a5_count", count_o, 1);
      end
    join
    chk("a5_ferr", ferr_cnt, 0);
    idle(4);
    drain("a5");

    // short low glitch is rejected at mid start bit
    hold(1'b0, 5);
    idle(30);
    chk("glitch_state", state_o, ST_IDLE);
    chk("glitch_count", count_o, 0);
    chk("glitch_valid", valid_o, 0);

    // framing error followed by a long break
    ferr_cnt = 0;
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40 * CPB);
    idle(8);
    chk("break_ferr_pulses", ferr_cnt, 1);
    chk("break_count", count_o, 0);
    chk("break_state", state_o, ST_IDLE);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(4);
    chk("after_break_count", count_o, 1);
    drain("after_break");

    // overrun on the fifth frame
    ovr_cnt = 0;
    ferr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      idle(4);
    end
    chk("ovr_count", count_o, DEPTH);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_ferr", ferr_cnt, 0);
    drain("ovr");

    // push and pop together while full: no overrun
    ovr_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1);
      idle(4);
    end
    chk("full_count", count_o, DEPTH);
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
      end
    join
    idle(4);
    chk("full_pushpop_count", count_o, DEPTH);
    chk("full_pushpop_ovr", ovr_cnt, 0);
    drain("full_pushpop");

    // reset in the middle of data bit 4
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (CPB + 4 * CPB + CPB / 2) @(posedge clk_i);
        #1;
        nreset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("midrst_count", count_o, 0);
        chk("midrst_valid", valid_o, 0);
        nreset_i = 1'b0;
      end
    join
    idle(8);
    chk("post_rst_count", count_o, 0);
    chk("post_rst_state", state_o, ST_IDLE);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    chk("5a_count", count_o, 1);
    drain("5a");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
